// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// Contents:
//   ARB_NREQ  - number of requesters (fixed at 4)
//   ARB_ID_W  - width of the requester key / select (fixed at 2)
//   ARB_CNT_W - width of the optional per-requester grant counters
//   arb_state_e - output buffer state (empty / full)
package mux_rr_arbiter_pkg;

  localparam int unsigned ARB_NREQ  = 4;
  localparam int unsigned ARB_ID_W  = 2;
  localparam int unsigned ARB_CNT_W = 16;

  localparam logic ARB_EMPTY = 1'b0;
  localparam logic ARB_FULL  = 1'b1;

  typedef enum logic {
    StEmpty = ARB_EMPTY,
    StFull  = ARB_FULL
  } arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_mux_key4.sv
// Purely combinational DATA_W-wide 4:1 mux driven by a 2-bit key.
// Ports:
//   key    - 2-bit select
//   in_bus - four DATA_W-bit values; value i occupies bits [i*DATA_W +: DATA_W]
//   out    - selected value
module mux_key4 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]          key,
  input  logic [4*DATA_W-1:0] in_bus,
  output logic [DATA_W-1:0]   out
);

  always_comb begin
    out = '0;
    case (key)
      2'd0:    out = in_bus[0*DATA_W +: DATA_W];
      2'd1:    out = in_bus[1*DATA_W +: DATA_W];
      2'd2:    out = in_bus[2*DATA_W +: DATA_W];
      default: out = in_bus[3*DATA_W +: DATA_W];
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a one-entry output buffer.
// The winner's key selects its payload through mux_key4; the payload, its key
// and a valid flag are registered and presented downstream with valid/ready.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   req_valid/ready   - per-requester handshake; req_ready is one-hot or zero
//   req_data          - payloads, requester i at [i*DATA_W +: DATA_W]
//   out_valid/ready   - downstream handshake
//   out_data, out_id  - buffered payload and the key of its requester
// Optional (macro ARB_GRANT_CNT_EN):
//   cnt_sel, cnt_out  - read port onto four saturating 16-bit grant counters
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ARB_NREQ-1:0]        req_valid,
  input  logic [ARB_NREQ*DATA_W-1:0] req_data,
  output logic [ARB_NREQ-1:0]        req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ARB_ID_W-1:0]        out_id,
  input  logic                       out_ready
`ifdef ARB_GRANT_CNT_EN
  ,
  input  logic [ARB_ID_W-1:0]        cnt_sel,
  output logic [ARB_CNT_W-1:0]       cnt_out
`endif
);

  arb_state_e          state_q, state_d;
  logic [ARB_ID_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ARB_ID_W-1:0] id_q, id_d;

  logic                can_accept;
  logic                gnt_valid;
  logic [ARB_ID_W-1:0] gnt_id;
  logic [ARB_ID_W-1:0] scan_idx;
  logic                fire;
  logic [DATA_W-1:0]   mux_out;

  // A full buffer can still accept when it is being drained this cycle.
  assign can_accept = (state_q == StEmpty) | out_ready;

  // Round-robin scan starting at ptr_q; the 2-bit add wraps modulo 4.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < ARB_NREQ; i++) begin
      scan_idx = ptr_q + ARB_ID_W'(i);
      if (!gnt_valid && req_valid[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = scan_idx;
      end
    end
  end

  assign fire = can_accept & gnt_valid;

  // Gated by rst_n so no requester sees an accept while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && fire) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  mux_key4 #(
    .DATA_W (DATA_W)
  ) u_mux_key4 (
    .key    (gnt_id),
    .in_bus (req_data),
    .out    (mux_out)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (fire) begin
      // Covers both fill-from-empty and drain-and-replace in one cycle.
      state_d = StFull;
      ptr_d   = gnt_id + ARB_ID_W'(1);
      data_d  = mux_out;
      id_d    = gnt_id;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_id    = id_q;

`ifdef ARB_GRANT_CNT_EN
  logic [ARB_NREQ-1:0][ARB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fire && (cnt_q[gnt_id] != '1)) begin
      cnt_d[gnt_id] = cnt_q[gnt_id] + ARB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out = cnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a vector table drives requests and
// downstream ready, expected grants are pushed to a scoreboard and popped as
// the buffered payload drains. Hand-written sequences cover reset, async reset
// while full and (with ARB_GRANT_CNT_EN) counter saturation.
module tb_mux_rr_arbiter;
  import mux_rr_arbiter_pkg::*;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req_valid;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]        req_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_id;
  logic              out_ready;
`ifdef ARB_GRANT_CNT_EN
  logic [1:0]        cnt_sel;
  logic [15:0]       cnt_out;
`endif

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
`ifdef ARB_GRANT_CNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
`endif
  );

  typedef struct packed {
    logic [3:0] rv;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_ov;
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[21];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] pay(input logic [1:0] id);
    pay = 32'hA5A5_0000 | 32'(id);
  endfunction

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    oh2id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) oh2id = 2'(i);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, check comb outputs and buffer mid-cycle.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    req_valid = v.rv;
    out_ready = v.ordy;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
    check({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
    if (v.exp_ov) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard: got an output, expected none pending", tag);
      end else begin
        check({tag, " out_id"}, 32'(out_id), 32'(sb[0].id));
        check({tag, " out_data"}, out_data, sb[0].data);
        if (v.ordy) void'(sb.pop_front());
      end
    end
    if (v.exp_ready != 4'b0000) begin
      e.id   = oh2id(v.exp_ready);
      e.data = pay(e.id);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          rv       ordy  exp_ready  exp_ov
    vecs[0]  = {4'b1111, 1'b1, 4'b0001, 1'b0}; // first grant after reset -> 0
    vecs[1]  = {4'b0100, 1'b1, 4'b0100, 1'b1}; // single request, ptr=1 -> 2
    vecs[2]  = {4'b0000, 1'b1, 4'b0000, 1'b1}; // drain id2, ptr=3
    vecs[3]  = {4'b0010, 1'b1, 4'b0010, 1'b0}; // wrap 3->0->1, ptr=2
    vecs[4]  = {4'b1001, 1'b1, 4'b1000, 1'b1}; // skip to 3, ptr=0
    vecs[5]  = {4'b1111, 1'b1, 4'b0001, 1'b1}; // rotation 0
    vecs[6]  = {4'b1111, 1'b1, 4'b0010, 1'b1}; // 1
    vecs[7]  = {4'b1111, 1'b1, 4'b0100, 1'b1}; // 2
    vecs[8]  = {4'b1111, 1'b1, 4'b1000, 1'b1}; // 3
    vecs[9]  = {4'b1111, 1'b1, 4'b0001, 1'b1}; // 0
    vecs[10] = {4'b1111, 1'b1, 4'b0010, 1'b1}; // buffer id1
    vecs[11] = {4'b1111, 1'b0, 4'b0000, 1'b1}; // backpressure x3
    vecs[12] = {4'b1111, 1'b0, 4'b0000, 1'b1};
    vecs[13] = {4'b1111, 1'b0, 4'b0000, 1'b1};
    vecs[14] = {4'b1111, 1'b1, 4'b0100, 1'b1}; // release -> grant 2
    vecs[15] = {4'b0000, 1'b1, 4'b0000, 1'b1}; // drain
    vecs[16] = {4'b0000, 1'b0, 4'b0000, 1'b0}; // idle, ptr stays 3
    vecs[17] = {4'b1111, 1'b0, 4'b1000, 1'b0}; // empty accepts without out_ready
    vecs[18] = {4'b0000, 1'b0, 4'b0000, 1'b1}; // hold
    vecs[19] = {4'b0000, 1'b1, 4'b0000, 1'b1}; // drain
    vecs[20] = {4'b0110, 1'b1, 4'b0010, 1'b0}; // ptr=0 -> grant 1, ptr=2

    req_data  = {pay(2'd3), pay(2'd2), pay(2'd1), pay(2'd0)};
    req_valid = 4'b1111;
    out_ready = 1'b0;
    rst_n     = 1'b0;
`ifdef ARB_GRANT_CNT_EN
    cnt_sel   = 2'd0;
`endif

    // Reset held with every requester asking.
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset out_id", 32'(out_id), 32'd0);
    check("reset out_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset while full: buffer must clear without a clock edge.
    req_valid = 4'b1111;
    out_ready = 1'b0;
    #2;
    check("pre-async out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'd0);
    check("async out_data", out_data, 32'd0);
    check("async out_id", 32'(out_id), 32'd0);
    check("async req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec({4'b1111, 1'b1, 4'b0001, 1'b0}, "post-reset"); // ptr back to 0
    run_vec({4'b0000, 1'b1, 4'b0000, 1'b1}, "post-drain");

`ifdef ARB_GRANT_CNT_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cnt_sel   = 2'd0;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cnt after 3", 32'(cnt_out), 32'd3);
    repeat (70000 - 3) @(posedge clk);
    #1;
    check("cnt saturated", 32'(cnt_out), 32'hFFFF);
    cnt_sel = 2'd1;
    #1;
    check("cnt other", 32'(cnt_out), 32'd0);
    cnt_sel   = 2'd0;
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    #1;
    check("cnt cleared", 32'(cnt_out), 32'd0);
    rst_n = 1'b1;
    sb.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
